// File: rtl/heap_op_arbiter.sv
// heap_op_arbiter: round-robin arbiter that lets NREQ requesters share one
// heap engine. One push/pop command is outstanding at a time. Full/empty
// rejections and engine timeouts come back as error responses.
module heap_op_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int TMO  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_v,
    input  logic [NREQ-1:0]           req_op,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic [NREQ-1:0]           req_ack,
    output logic                      rsp_v,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [DW-1:0]             rsp_data,
    output logic                      rsp_err,
    output logic                      heap_cmd_v,
    output logic                      heap_cmd_op,
    output logic [DW-1:0]             heap_cmd_data,
    input  logic                      heap_busy,
    input  logic                      heap_done,
    input  logic [DW-1:0]             heap_rdata,
    input  logic                      heap_full,
    input  logic                      heap_empty
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   win_id;
    logic            reject_q;
    logic [CW-1:0]   tmo_cnt;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            pick_op;
    logic [DW-1:0]   pick_data;
    logic            reject;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NREQ);
            if (!found && req_v[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_op   = req_op[pick];
        pick_data = req_data[pick*DW +: DW];
        // Occupancy is judged when the request is sampled, so the command
        // strobe can be a plain register in the following cycle.
        reject    = pick_op ? heap_empty : heap_full;
    end

    // Control FSM; every output is a register loaded on state transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= IW'(NREQ - 1);
            win_id        <= '0;
            reject_q      <= 1'b0;
            tmo_cnt       <= '0;
            req_ack       <= '0;
            rsp_v         <= 1'b0;
            rsp_id        <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            heap_cmd_v    <= 1'b0;
            heap_cmd_op   <= 1'b0;
            heap_cmd_data <= '0;
        end else begin
            req_ack    <= '0;
            rsp_v      <= 1'b0;
            heap_cmd_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && !heap_busy) begin
                        win_id        <= pick;
                        reject_q      <= reject;
                        req_ack       <= NREQ'(1) << pick;
                        heap_cmd_v    <= !reject;
                        heap_cmd_op   <= pick_op;
                        heap_cmd_data <= pick_data;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    last_grant <= win_id;
                    tmo_cnt    <= '0;
                    if (reject_q) begin
                        rsp_v    <= 1'b1;
                        rsp_id   <= win_id;
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (heap_done) begin
                        rsp_v    <= 1'b1;
                        rsp_id   <= win_id;
                        rsp_data <= heap_cmd_op ? heap_rdata : '0;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (tmo_cnt == CW'(TMO - 1)) begin
                        rsp_v    <= 1'b1;
                        rsp_id   <= win_id;
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        tmo_cnt  <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_op_arbiter.sv
// Bench for heap_op_arbiter: table of single-request vectors plus hand-written
// fairness, timeout, busy and reset sequences, with a response scoreboard.
module tb_heap_op_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_v = '0;
    logic [3:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ack;
    logic        rsp_v;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        heap_cmd_v;
    logic        heap_cmd_op;
    logic [7:0]  heap_cmd_data;
    logic        heap_busy = 1'b0;
    logic        heap_done = 1'b0;
    logic [7:0]  heap_rdata = 8'hEE;
    logic        heap_full = 1'b0;
    logic        heap_empty = 1'b0;

    heap_op_arbiter #(.NREQ(4), .DW(8), .TMO(64)) dut (
        .clk(clk), .reset(reset),
        .req_v(req_v), .req_op(req_op), .req_data(req_data),
        .req_ack(req_ack), .rsp_v(rsp_v), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .heap_cmd_v(heap_cmd_v), .heap_cmd_op(heap_cmd_op),
        .heap_cmd_data(heap_cmd_data),
        .heap_busy(heap_busy), .heap_done(heap_done), .heap_rdata(heap_rdata),
        .heap_full(heap_full), .heap_empty(heap_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  rop;
        logic [31:0] rdat;
        logic        full;
        logic        empty;
        logic [7:0]  rdata;
        int          dly;
        int          exp_id;
        logic        exp_err;
        logic [7:0]  exp_data;
        logic        exp_cmd;
        logic [7:0]  exp_cdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_total = 0;
    int   rsp_total = 0;
    int   viol = 0;
    int   done_dly = 1;
    logic [7:0] rdata_cfg = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Heap engine model: answers each command after done_dly cycles (never if < 0).
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && heap_cmd_v && done_dly >= 0) begin
                repeat (done_dly) @(negedge clk);
                heap_done  = 1'b1;
                heap_rdata = rdata_cfg;
                @(negedge clk);
                heap_done  = 1'b0;
                heap_rdata = 8'hEE;
            end
        end
    end

    // Response scoreboard and output exclusivity monitor.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (req_ack != 0) ack_total++;
                if ((req_ack != 0 && rsp_v) || (heap_cmd_v && rsp_v) || $countones(req_ack) > 1)
                    viol++;
                if (rsp_v) begin
                    rsp_total++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected id=%0d data=%0h err=%0b", rsp_id, rsp_data, rsp_err);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_fields", {rsp_id, rsp_data, rsp_err}, {e.id, e.data, e.err});
                    end
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input string name);
        rsp_t e;
        int lat;
        logic [3:0] ackv;
        logic cmd_seen, got;
        logic [7:0] cdata;
        @(posedge clk); #1;
        heap_full  = v.full;
        heap_empty = v.empty;
        rdata_cfg  = v.rdata;
        done_dly   = v.dly;
        req_v      = v.rv;
        req_op     = v.rop;
        req_data   = v.rdat;
        e.id = 2'(v.exp_id); e.data = v.exp_data; e.err = v.exp_err;
        sb.push_back(e);
        lat = 0; ackv = '0; cmd_seen = 1'b0; cdata = '0; got = 1'b0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (req_ack != 0) ackv = req_ack;
            if (heap_cmd_v) begin cmd_seen = 1'b1; cdata = heap_cmd_data; end
            if (rsp_v) begin got = 1'b1; req_v = '0; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s no_response actual=none required=rsp_v", name);
            req_v = '0;
        end
        chk({name, "_ack"}, 32'(ackv), 32'(4'b1 << v.exp_id));
        chk({name, "_cmd"}, 32'(cmd_seen), 32'(v.exp_cmd));
        if (v.exp_cmd) chk({name, "_cdata"}, 32'(cdata), 32'(v.exp_cdata));
        if (v.exp_lat > 0) chk({name, "_lat"}, 32'(lat), 32'(v.exp_lat));
        repeat (3) @(negedge clk);
        heap_full = 1'b0; heap_empty = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        vec_t v;
        rsp_t e;
        int grants[5];
        int ng, nr, cyc, a0, r0;
        logic [3:0] ackv;

        //            rv     rop    rdat          f  e  rdata dly id err data cmd cdata lat
        vecs[0] = '{4'b0001, 4'b0000, 32'h0000002A, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 8'h2A, 4};
        vecs[1] = '{4'b0100, 4'b0100, 32'h00000000, 0, 0, 8'h50, 1, 2, 0, 8'h50, 1, 8'h00, 4};
        vecs[2] = '{4'b0100, 4'b0100, 32'h00000000, 0, 1, 8'h50, 1, 2, 1, 8'h00, 0, 8'h00, 3};
        vecs[3] = '{4'b1000, 4'b0000, 32'hAB000000, 1, 0, 8'h00, 1, 3, 1, 8'h00, 0, 8'h00, 3};
        vecs[4] = '{4'b0011, 4'b0000, 32'h00002211, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 8'h11, 4};
        vecs[5] = '{4'b0011, 4'b0000, 32'h00002211, 0, 0, 8'h00, 1, 1, 0, 8'h00, 1, 8'h22, 4};
        vecs[6] = '{4'b1111, 4'b1111, 32'h00000000, 0, 0, 8'h77, 1, 2, 0, 8'h77, 1, 8'h00, 4};
        vecs[7] = '{4'b0001, 4'b0001, 32'h00000000, 1, 0, 8'h9C, 1, 0, 0, 8'h9C, 1, 8'h00, 4};
        vecs[8] = '{4'b0010, 4'b0000, 32'h00003300, 0, 1, 8'h00, 1, 1, 0, 8'h00, 1, 8'h33, 4};
        vecs[9] = '{4'b1000, 4'b1000, 32'h00000000, 0, 0, 8'h5A, 3, 3, 0, 8'h5A, 1, 8'h00, 6};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({req_ack, rsp_v, rsp_id, rsp_data, rsp_err, heap_cmd_v,
                                  heap_cmd_op, heap_cmd_data}), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Fairness: all four requesters held, five grants observed
        done_dly = 1;
        for (int i = 0; i < 5; i++) begin
            e.id = 2'(i % 4); e.data = 8'h00; e.err = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_op = 4'b0000; req_data = 32'h04030201; req_v = 4'b1111;
        ng = 0; nr = 0; cyc = 0;
        while (nr < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (req_ack != 0 && ng < 5) begin
                ackv = req_ack;
                for (int b = 0; b < 4; b++) if (ackv[b]) grants[ng] = b;
                ng++;
            end
            if (rsp_v) begin
                nr++;
                if (nr == 5) req_v = '0;
            end
        end
        req_v = '0;
        chk("fair_count", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fair_grant%0d", i), 32'(grants[i]), 32'(i % 4));
            if (i > 0) begin
                checks++;
                if (grants[i] == grants[i-1]) begin
                    errors++;
                    $display("FAIL fair_repeat%0d actual=%0d required=not_%0d", i, grants[i], grants[i-1]);
                end
            end
        end
        repeat (3) @(negedge clk);

        // Table-driven single requests
        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Timeout: never completed, 64 WAIT cycles then error
        v = '{4'b0001, 4'b0000, 32'h00000001, 0, 0, 8'h00, -1, 0, 1, 8'h00, 1, 8'h01, 67};
        run_vec(v, "tmo_never");
        v = '{4'b0010, 4'b0010, 32'h00000000, 0, 0, 8'h44, 1, 1, 0, 8'h44, 1, 8'h00, 4};
        run_vec(v, "tmo_recover");
        v = '{4'b0100, 4'b0100, 32'h00000000, 0, 0, 8'h66, 64, 2, 0, 8'h66, 1, 8'h00, 67};
        run_vec(v, "tmo_done_at_limit");
        v = '{4'b1000, 4'b1000, 32'h00000000, 0, 0, 8'h55, 65, 3, 1, 8'h00, 1, 8'h00, 67};
        run_vec(v, "tmo_done_late");
        repeat (3) @(negedge clk);

        // heap_busy holds off the grant
        heap_busy = 1'b1;
        a0 = ack_total;
        v = '{4'b0001, 4'b0000, 32'h00000010, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 8'h10, -1};
        fork
            run_vec(v, "busy");
            begin
                repeat (10) @(negedge clk);
                chk("busy_no_grant", 32'(ack_total - a0), 32'd0);
                heap_busy = 1'b0;
            end
        join

        // Reset during WAIT aborts silently; next grant favours requester 0
        done_dly = -1;
        @(posedge clk); #1;
        req_op = 4'b0000; req_data = 32'h0000005F; req_v = 4'b0001;
        cyc = 0;
        while (!heap_cmd_v && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rst_cmd_seen", 32'(heap_cmd_v), 32'd1);
        req_v = '0;
        @(negedge clk);
        r0 = rsp_total;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", 32'({req_ack, rsp_v, rsp_id, rsp_data, rsp_err, heap_cmd_v,
                                    heap_cmd_op, heap_cmd_data}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_rsp", 32'(rsp_total - r0), 32'd0);
        v = '{4'b0011, 4'b0000, 32'h00000807, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 8'h07, 4};
        run_vec(v, "rst_regrant");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("exclusivity", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/heap_op_arbiter.md
HEAP_OP_ARBITER -- requirements
Module: heap_op_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the heap engine.
REQ-002 Parameter DW, default 8, heap element width.
REQ-003 Parameter TMO, default 64, max cycles waiting for heap completion before timeout.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req_v  input  NREQ  per-requester request valid; held until acknowledged.
REQ-007 req_op  input  NREQ  per-requester op: 0 push, 1 pop.
REQ-008 req_data  input  NREQ*DW  per-requester push value; requester i at bits [i*DW +: DW].
REQ-009 req_ack  output  NREQ  one-hot single-cycle pulse; request accepted.
REQ-010 rsp_v  output  1  single-cycle response valid.
REQ-011 rsp_id  output  clog2(NREQ)  index of requester owning the response.
REQ-012 rsp_data  output  DW  popped value; 0 for push or error.
REQ-013 rsp_err  output  1  operation rejected (full/empty) or timed out.
REQ-014 heap_cmd_v  output  1  single-cycle command strobe to heap engine.
REQ-015 heap_cmd_op  output  1  0 push, 1 pop; valid with heap_cmd_v.
REQ-016 heap_cmd_data  output  DW  push value; valid with heap_cmd_v.
REQ-017 heap_busy  input  1  heap engine restructuring; no command may issue.
REQ-018 heap_done  input  1  single-cycle pulse; current command complete.
REQ-019 heap_rdata  input  DW  popped root value; valid with heap_done.
REQ-020 heap_full, heap_empty  input  1 each  heap occupancy flags.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; exactly one heap command outstanding at any time.
REQ-022 IDLE: if any req_v=1 and heap_busy=0, register winner index, op, data; next state ISSUE; else remain.
REQ-023 Arbitration round-robin: search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1 so requester 0 wins first.
REQ-024 ISSUE (one cycle): req_ack[winner]=1; last_grant<=winner.
REQ-025 ISSUE, push with heap_full=1 or pop with heap_empty=1: heap_cmd_v=0; next RESP with rsp_err=1, rsp_data=0.
REQ-026 ISSUE otherwise: heap_cmd_v=1, heap_cmd_op/data from registered request; clear timeout counter; next WAIT.
REQ-027 WAIT: on heap_done=1 capture heap_rdata (pop) or 0 (push), err=0, next RESP.
REQ-028 WAIT: counter increments each cycle without heap_done; at count TMO-1 next RESP with rsp_err=1, rsp_data=0.
REQ-029 heap_done in the same cycle as the timeout threshold takes precedence (normal completion).
REQ-030 heap_done outside WAIT is ignored.
REQ-031 RESP (one cycle): rsp_v=1 with rsp_id, rsp_data, rsp_err; next IDLE.
REQ-032 Minimum latency request-to-rsp_v: 4 cycles (IDLE sample, ISSUE, WAIT with immediate done, RESP); error path 3 cycles.
REQ-033 Requests arriving or dropped while not in IDLE have no effect; deasserting req_v before ack is legal and loses the request.
REQ-034 req_ack, rsp_v, heap_cmd_v are never asserted in the same cycle as each other except req_ack with heap_cmd_v.
REQ-035 All outputs registered or decoded from state and registered fields only; no combinational path from inputs to outputs.

Reset
REQ-036 Reset forces state IDLE, last_grant NREQ-1, timeout counter 0, req_ack 0, rsp_v 0, rsp_id 0, rsp_data 0, rsp_err 0, heap_cmd_v 0, heap_cmd_op 0, heap_cmd_data 0.
REQ-037 Reset asserted mid-operation aborts it without response; first post-reset grant again favours requester 0.

Verification
REQ-038 Single push: req_v=0001, op push, data 0x2A, heap_done 1 cycle after cmd -> heap_cmd_v with data 0x2A, req_ack=0001, rsp_v rsp_id=0 err=0 data=0.
REQ-039 Pop: heap holds 0x50, requester 2 pops, heap_done with heap_rdata=0x50 -> rsp_id=2, rsp_data=0x50, err=0.
REQ-040 Fairness: req_v=1111 held, each reacquired after ack -> grant order 0,1,2,3,0; no requester granted twice consecutively.
REQ-041 Pop with heap_empty=1 -> no heap_cmd_v, rsp_err=1, rsp_data=0, 3-cycle latency; same for push with heap_full=1.
REQ-042 heap_done never returned, TMO=64 -> rsp_v with rsp_err=1 exactly 64 WAIT cycles after heap_cmd_v; next request serviced normally.
REQ-043 heap_busy=1 with req_v pending -> no grant until heap_busy falls; reset during WAIT -> no rsp_v, all outputs 0.
